// File: rtl/first_bit_place.sv
// Sequential leading-one placer: shifts a normalized mantissa right so its MSB lands at in_pos,
// resolving one power-of-two shift stage per clock (MSB stage first) and collecting a sticky bit.
module first_bit_place #(
   parameter int unsigned WIDTH = 32,
   localparam int unsigned L2 = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_mant,
   input  logic [L2-1:0]    in_pos,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_value,
   output logic             out_sticky,
   output logic             out_clamped
);

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StDone
   } state_e;

   localparam logic [L2-1:0] MaxPos   = L2'(WIDTH - 1);
   localparam logic [L2-1:0] TopStage = L2'(L2 - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             sticky_q, sticky_d;
   logic             clamped_q, clamped_d;
   logic [L2-1:0]    k_q, k_d;
   logic [L2-1:0]    s_q, s_d;

   logic [L2-1:0]    pos_eff;
   int unsigned      stage_amt;
   logic [WIDTH-1:0] stage_mask;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         data_q    <= '0;
         sticky_q  <= 1'b0;
         clamped_q <= 1'b0;
         k_q       <= '0;
         s_q       <= '0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         sticky_q  <= sticky_d;
         clamped_q <= clamped_d;
         k_q       <= k_d;
         s_q       <= s_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      sticky_d   = sticky_q;
      clamped_d  = clamped_q;
      k_d        = k_q;
      s_d        = s_q;
      pos_eff    = (in_pos > MaxPos) ? MaxPos : in_pos;
      stage_amt  = 32'd1 << k_q;
      // Bits that fall off the bottom when this stage shifts by 2^k.
      stage_mask = ~({WIDTH{1'b1}} << stage_amt);

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               data_d    = in_mant;
               sticky_d  = 1'b0;
               clamped_d = (in_pos > MaxPos);
               s_d       = MaxPos - pos_eff;
               k_d       = TopStage;
               state_d   = StShift;
            end
         end
         StShift: begin
            if (s_q[k_q]) begin
               sticky_d = sticky_q | (|(data_q & stage_mask));
               data_d   = data_q >> stage_amt;
            end
            if (k_q == '0) begin
               state_d = StDone;
            end else begin
               k_d = k_q - 1'b1;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign in_ready    = (state_q == StIdle) && !rst;
   assign out_valid   = (state_q == StDone);
   assign out_value   = data_q;
   assign out_sticky  = sticky_q;
   assign out_clamped = clamped_q;

endmodule

// File: doc/first_bit_place.md
# first_bit_place

Sequential leading-one placer for the FPU datapath. It is the inverse of the leading-one position encoder used in normalization. It takes a normalized mantissa, whose leading one sits at the MSB, and a target bit position. It shifts the mantissa right so the MSB lands at that position and reports a sticky OR of every bit shifted out. The FPU uses it for denormalization, exponent alignment and float-to-integer conversion. One shift stage is resolved per clock, MSB stage first, so the per-stage mux depth matches the position encoder's.

## Interface
- WIDTH, default 32: data width; must be >= 2. L2 = $clog2(WIDTH).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept; equals (state == IDLE) && !rst.
- in_mant  in  WIDTH  mantissa; bit WIDTH-1 is normally set but this is not required.
- in_pos  in  L2  target position of mantissa bit WIDTH-1 in the result.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_value  out  WIDTH  shifted mantissa.
- out_sticky  out  1  OR of all bits shifted out below bit 0.
- out_clamped  out  1  in_pos exceeded WIDTH-1 and was saturated.

## Operation
- States: IDLE, SHIFT, DONE. Reset puts the block in IDLE.
- Reset values: out_valid=0, out_value=0, out_sticky=0, out_clamped=0, stage counter=0. in_ready is 0 while rst is high.
- IDLE: in_valid && in_ready at an edge accepts the request:
  - data <= in_mant, sticky <= 0.
  - pos_eff = min(in_pos, WIDTH-1); clamped <= (in_pos > WIDTH-1). Clamping is only possible when WIDTH is not a power of two.
  - s <= WIDTH-1-pos_eff, held in L2 bits.
  - k <= L2-1; next state SHIFT.
- SHIFT: each edge processes stage k:
  - If s[k] = 1: sticky |= |data[2^k-1:0], then data <= data >> 2^k (zero fill).
  - If s[k] = 0: data and sticky are unchanged.
  - If k == 0, next state DONE; otherwise k <= k-1.
- DONE: out_valid=1. out_value, out_sticky and out_clamped are driven from registers and are stable while out_valid is high.
  - out_valid && out_ready at an edge moves the block to IDLE. out_valid drops after that edge.
  - out_ready low keeps the block in DONE indefinitely.
- in_ready is 0 in SHIFT and DONE. Only one transaction is in flight at a time, with no overlap between output handshake and input acceptance.
- Arithmetic: the result equals in_mant >> (WIDTH-1-pos_eff), truncated. Sticky = |(in_mant & ((1 << shift) - 1)).
- Zero mantissa gives out_value=0 and out_sticky=0, with the same latency as any other input.
- pos_eff = WIDTH-1 gives shift 0: value passes through unchanged, sticky=0, still L2 SHIFT cycles.
- in_valid while in_ready=0 is ignored. Upstream holds the request until it is accepted.

## Timing
- Latency is fixed and independent of data. Accept at edge T; SHIFT occupies edges T+1..T+L2; out_valid is high after edge T+L2. For WIDTH=32: 5 cycles.
- Earliest next accept: the output handshake at edge T+L2+1 returns the block to IDLE, and the next accept is at edge T+L2+2. Throughput is 1 result per L2+2 cycles.
- rst high at any edge, in any state including mid-SHIFT or DONE, forces IDLE and the reset values at that edge. The in-flight transaction is discarded and never reaches the output. in_valid on the reset edge is not accepted.
- rst and a handshake at the same edge: reset wins.
- Outputs depend only on registers. in_ready is the state decode gated by rst.

## Test plan
- WIDTH=32, in_mant=0x80000000, in_pos=0 -> after 5 cycles out_value=0x00000001, out_sticky=0, out_clamped=0.
- WIDTH=32, in_mant=0xC0000001, in_pos=4 -> out_value=0x00000018, out_sticky=1. Also in_mant=0xFFFFFFFF, in_pos=31 -> out_value=0xFFFFFFFF, out_sticky=0, still 5-cycle latency.
- WIDTH=24 (L2=5), in_mant=0x800000, in_pos=30 -> out_clamped=1, out_value=0x800000, out_sticky=0. Same input with in_pos=20 -> out_value=0x100000, out_clamped=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid, out_value and out_sticky stay constant, in_ready=0. Raise out_ready -> out_valid drops after 1 edge, in_ready=1 on the following cycle.
- Reset mid-SHIFT (rst high at edge T+2) -> out_valid never rises, next cycle in_ready=1. A new request (0x80000000, pos 31) completes normally with out_value=0x80000000.
- Random back-to-back stream of 1000 transactions with random in_valid and out_ready against the shift/sticky reference formula -> zero mismatches, no dropped or duplicated results.
